// File: rtl/uart_tx_gen2_if.sv
// Write-side handshake of the UART transmitter: the producer offers P_DATA with
// Data_Valid, and the transmitter answers with Ready while its FIFO has room.
interface uart_tx_gen2_if #(
  parameter int DATA_W = 8
);
  logic              Data_Valid;
  logic [DATA_W-1:0] P_DATA;
  logic              Ready;

  modport master (output Data_Valid, output P_DATA, input Ready);
  modport slave  (input Data_Valid, input P_DATA, output Ready);
endinterface

// File: rtl/uart_tx_gen2.sv
// UART transmitter with a small write FIFO, optional parity and one or two stop bits.
// Line settings are captured at each frame start so mid-frame changes only affect later frames.
module uart_tx_gen2 #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE_W = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  input  logic                          STOP2,
  input  logic [PRESCALE_W-1:0]         PRESCALE,
  uart_tx_gen2_if.slave                 bus_if,
  output logic                          TX_OUT,
  output logic                          Busy,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_W);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  state_t                state_q;
  logic [PRESCALE_W-1:0] presc_q, cnt_q, presc_live;
  logic [BW-1:0]         bit_q;
  logic [DATA_W-1:0]     sh_q;
  logic                  stop_q, par_en_q, stop2_q, par_q;
  logic                  tx_q, busy_q;
  logic                  push, pop, empty, full, bit_end, last_stop;

  assign presc_live = (PRESCALE == '0) ? PRESCALE_W'(1) : PRESCALE;
  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_CNT);
  assign bit_end    = (cnt_q == '0);
  // Second stop bit still pending means the frame has not finished yet.
  assign last_stop  = (state_q == STOP) && bit_end && !(stop2_q && !stop_q);

  // Both decisions use the registered count, so a word pushed into an empty
  // FIFO is popped one cycle later and a pop never frees room for a same-cycle push.
  assign push = bus_if.Data_Valid && !full && !RST;
  assign pop  = !RST && !empty && ((state_q == IDLE) || last_stop);

  assign bus_if.Ready = !full;
  assign TX_OUT       = tx_q;
  assign Busy         = busy_q;
  assign Fifo_Count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= bus_if.P_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
    end else if (pop) begin
      state_q  <= START;
      tx_q     <= 1'b0;
      busy_q   <= 1'b1;
      cnt_q    <= presc_live - PRESCALE_W'(1);
      presc_q  <= presc_live;
      par_en_q <= PAR_EN;
      stop2_q  <= STOP2;
      par_q    <= (^mem_q[rd_ptr_q]) ^ PAR_TYP;
      sh_q     <= mem_q[rd_ptr_q];
    end else if (state_q != IDLE) begin
      if (!bit_end) begin
        cnt_q <= cnt_q - PRESCALE_W'(1);
      end else begin
        cnt_q <= presc_q - PRESCALE_W'(1);
        case (state_q)
          START: begin
            state_q <= DATA;
            tx_q    <= sh_q[0];
            sh_q    <= {1'b0, sh_q[DATA_W-1:1]};
            bit_q   <= '0;
          end
          DATA: begin
            if (bit_q == BW'(DATA_W - 1)) begin
              if (par_en_q) begin
                state_q <= PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
                stop_q  <= 1'b0;
              end
            end else begin
              bit_q <= bit_q + BW'(1);
              tx_q  <= sh_q[0];
              sh_q  <= {1'b0, sh_q[DATA_W-1:1]};
            end
          end
          PARITY: begin
            state_q <= STOP;
            tx_q    <= 1'b1;
            stop_q  <= 1'b0;
          end
          STOP: begin
            if (stop2_q && !stop_q) begin
              stop_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/uart_tx_gen2.md
UART_TX_GEN2 -- requirements
Module: uart_tx_gen2

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, 2..16.
REQ-003 Parameter PRESCALE_W, default 16, width of the PRESCALE input.
REQ-004 The block SHALL use one clock and one synchronous, active-high reset; ports listed in REQ-005..REQ-016.
REQ-005 CLK  input  1  clock; all logic on rising edge.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 PAR_EN  input  1  1 = append parity bit.
REQ-008 PAR_TYP  input  1  0 = even, 1 = odd parity.
REQ-009 STOP2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-010 PRESCALE  input  PRESCALE_W  CLK cycles per bit; value 0 treated as 1.
REQ-011 Data_Valid  input  1  write strobe for P_DATA.
REQ-012 P_DATA  input  DATA_W  word to transmit.
REQ-013 Ready  output  1  FIFO not full; write accepted when Data_Valid && Ready.
REQ-014 TX_OUT  output  1  serial line, idle high, registered.
REQ-015 Busy  output  1  high while a frame is on the line.
REQ-016 Fifo_Count  output  $clog2(FIFO_DEPTH)+1  words held in FIFO.

Function
REQ-017 Frame SHALL be: start bit 0, DATA_W data bits LSB first, optional parity, 1 or 2 stop bits of 1.
REQ-018 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; IDLE->START when FIFO non-empty; START->DATA; DATA->PARITY (PAR_EN) or STOP after bit DATA_W-1; PARITY->STOP; STOP->START if FIFO non-empty at end of last stop bit, else IDLE.
REQ-019 Each bit SHALL last exactly max(PRESCALE,1) cycles, timed by a down-counter reloaded at every bit boundary.
REQ-020 PAR_EN, PAR_TYP, STOP2, PRESCALE SHALL be latched on the IDLE->START or STOP->START transition; changes mid-frame do not affect the current frame.
REQ-021 Parity bit SHALL be XOR of the latched word (even) or its inverse (odd).
REQ-022 Pop SHALL occur on the START transition; word latched into a shift register in the same cycle.
REQ-023 Latency: write accepted at edge k into an empty FIFO with FSM in IDLE -> TX_OUT low from edge k+1.
REQ-024 Back-to-back frames SHALL have no idle cycle between last stop bit and next start bit.
REQ-025 Data_Valid with Ready low SHALL be ignored; word dropped, FIFO unchanged.
REQ-026 Ready SHALL reflect current fullness only; a pop in the same cycle does not enable a push when full.
REQ-027 Push into empty FIFO and pop SHALL not occur in the same cycle (pop sees registered count).
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; Fifo_Count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-029 Busy SHALL be high in every state except IDLE, registered with the state.

Reset
REQ-030 RST SHALL set TX_OUT=1, Busy=0, Ready=1, Fifo_Count=0, state IDLE, pointers and counters 0.
REQ-031 RST asserted mid-frame SHALL abort the frame; TX_OUT=1 from the next edge, FIFO contents discarded.
REQ-032 RST SHALL dominate Data_Valid in the same cycle; no write accepted.

Verification
REQ-033 PRESCALE=1, PAR_EN=1, PAR_TYP=0, write 0xA5 -> TX_OUT per cycle 0,1,0,1,0,0,1,0,1,0,1; Busy high 11 cycles.
REQ-034 Same with PAR_TYP=1 -> parity bit 1, other bits unchanged.
REQ-035 PRESCALE=4, PAR_EN=0, STOP2=1, write 0x0F -> each bit 4 cycles, frame 44 cycles, final 8 cycles high.
REQ-036 PRESCALE=16, FIFO_DEPTH=4, Data_Valid high 6 consecutive cycles from idle (words 1..6) -> words 1..5 accepted, Ready low at 6th write, word 6 dropped, 5 contiguous frames.
REQ-037 RST pulsed during data bit 3 with 2 words queued -> TX_OUT=1, Busy=0, Fifo_Count=0 next cycle; no further frames.
REQ-038 PRESCALE changed 4->8 during frame -> current frame stays 4 cycles/bit, next frame 8.
